adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, 2 to 8.
REQ-002 SHALL have parameter WIDTH, default 32: operand and sum width.
REQ-003 SHALL have port CLK, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port RSTN, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port REQ, input, NREQ: REQ[i] = requester i wants one add.
REQ-006 SHALL have port A_IN, input, NREQ*WIDTH: requester i operand A at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port B_IN, input, NREQ*WIDTH: requester i operand B, same packing.
REQ-008 SHALL have port LOCK, input, NREQ: chain request; present only with ADDER_ARB_CHAIN_EN.
REQ-009 SHALL have port GNT, output, NREQ: one-hot combinational grant; operands sampled at this edge.
REQ-010 SHALL have port RVALID, output, 1: result valid, one cycle per grant.
REQ-011 SHALL have port RID, output, clog2(NREQ): index of the requester owning the result.
REQ-012 SHALL have port Y, output, WIDTH: registered sum.
REQ-013 SHALL have port CB, output, 1: registered carry-out.

Function
REQ-014 SHALL keep a round-robin pointer PTR; search REQ from PTR upward, modulo NREQ; grant the first set bit.
REQ-015 SHALL drive at most one GNT bit; GNT = 0 when REQ = 0.
REQ-016 SHALL update PTR to (i+1) mod NREQ after granting i; PTR holds when nothing is granted.
REQ-017 SHALL register Y = (A+B+cin) mod 2^WIDTH and CB = carry-out, with RVALID=1 and RID=i, on the edge where GNT[i]=1; latency 1 cycle.
REQ-018 SHALL sustain one grant per cycle; back-to-back grants give back-to-back RVALID.
REQ-019 SHALL hold Y, CB and RID when RVALID=0.
REQ-020 SHALL treat REQ still high after GNT as a new request that competes normally.
REQ-021 SHALL use cin=0 except in the LOCKED state (REQ-026).

Reset
REQ-022 SHALL, on RSTN low, immediately force PTR=0, RVALID=0, RID=0, Y=0, CB=0, state ARB, saved carry 0.
REQ-023 SHALL force GNT=0 while RSTN is low.
REQ-024 SHALL, if reset is asserted mid-chain, abandon the chain; the first grant after release uses cin=0.

Configuration
REQ-025 SHALL use macro ADDER_ARB_CHAIN_EN to compile in multi-word carry chaining.
REQ-026 SHALL, with the macro, implement an FSM ARB/LOCKED; a grant to i with LOCK[i]=1 in ARB moves to LOCKED, records owner=i and saves the CB.
REQ-027 SHALL, in LOCKED, grant only the owner when REQ[owner]=1, using cin=saved carry; others stall; saved carry updates on each grant.
REQ-028 SHALL, in LOCKED, return to ARB with PTR=owner+1 after a granted word with LOCK[owner]=0; state holds while REQ[owner]=0.
REQ-029 SHALL, without the macro, have no LOCK port and no LOCKED state, with cin always 0.

Verification
REQ-030 SHALL cover: REQ=4'b0100, A=0xFFFFFFFF, B=1 -> GNT=4'b0100 same cycle; next cycle RVALID=1, RID=2, Y=0, CB=1.
REQ-031 SHALL cover: REQ=4'b1111 held 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3 with RVALID every cycle.
REQ-032 SHALL cover: PTR=2, REQ=4'b1010 -> grant 3, then grant 1.
REQ-033 SHALL cover, macro on: req0 issues LOCK=1, 0xFFFFFFFF+1, then LOCK=0, 0+0, while REQ[1]=1 -> Y=0/CB=1, then Y=1/CB=0; req1 granted only afterwards.
REQ-034 SHALL cover, macro on: RSTN pulsed low between the two chained words -> all outputs 0; after release, req0 0+0 -> Y=0, CB=0.
REQ-035 SHALL cover, macro off: the REQ-033 stimulus without LOCK -> second result Y=0, and req1 is granted between the two req0 words.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter in front of a single shared adder.
// Each cycle at most one requester is granted (GNT is combinational); its
// operands are summed and the registered result appears one cycle later with
// RVALID, RID, Y and CB.
// Optional feature: define ADDER_ARB_CHAIN_EN to add the LOCK port and an
// ARB/LOCKED FSM that lets one requester chain multi-word adds through a
// saved carry. Without the macro the carry-in is always zero.
module adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic [NREQ-1:0]               REQ,
  input  logic [NREQ*WIDTH-1:0]         A_IN,
  input  logic [NREQ*WIDTH-1:0]         B_IN,
`ifdef ADDER_ARB_CHAIN_EN
  input  logic [NREQ-1:0]               LOCK,
`endif
  output logic [NREQ-1:0]               GNT,
  output logic                          RVALID,
  output logic [$clog2(NREQ)-1:0]       RID,
  output logic [WIDTH-1:0]              Y,
  output logic                          CB
);

  localparam int IDW = $clog2(NREQ);

  // Round-robin pointer and registered result
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             rvalid_q, rvalid_d;
  logic [IDW-1:0]   rid_q, rid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cb_q, cb_d;

  // Round-robin search result
  logic             rr_found_s;
  logic [IDW-1:0]   rr_idx_s;
  int               idx_v;

  // Final grant decision (round-robin or chain owner)
  logic             grant_valid_s;
  logic [IDW-1:0]   grant_idx_s;
  logic             cin_s;
  logic [NREQ-1:0]  gnt_s;

  // Shared adder datapath
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;
  logic [WIDTH:0]   sum_s;

`ifdef ADDER_ARB_CHAIN_EN
  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic             carry_q, carry_d;
`endif

  // Search REQ upward from the pointer, wrapping modulo NREQ; first set bit wins
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    idx_v      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = int'(ptr_q) + k;
      if (idx_v >= NREQ) begin
        idx_v = idx_v - NREQ;
      end else begin
        idx_v = idx_v;
      end
      if (!rr_found_s && REQ[idx_v]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = IDW'(idx_v);
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

`ifdef ADDER_ARB_CHAIN_EN
  // While a chain is locked only the owner may be granted, using the saved carry
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    cin_s         = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant_valid_s = REQ[owner_q];
      grant_idx_s   = owner_q;
      cin_s         = carry_q;
    end else begin
      grant_valid_s = rr_found_s;
      grant_idx_s   = rr_idx_s;
      cin_s         = 1'b0;
    end
  end
`else
  // Without chaining the round-robin winner is always the grant and cin is zero
  always_comb begin
    grant_valid_s = rr_found_s;
    grant_idx_s   = rr_idx_s;
    cin_s         = 1'b0;
  end
`endif

  // One-hot grant, suppressed while reset is held so nothing looks granted
  always_comb begin
    gnt_s = '0;
    if (RSTN && grant_valid_s) begin
      gnt_s[grant_idx_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  // Operand mux for the granted requester and the shared adder
  always_comb begin
    a_sel_s = A_IN[grant_idx_s*WIDTH +: WIDTH];
    b_sel_s = B_IN[grant_idx_s*WIDTH +: WIDTH];
    sum_s   = {1'b0, a_sel_s} + {1'b0, b_sel_s} + {{WIDTH{1'b0}}, cin_s};
  end

  // Next result and pointer: capture the sum on a grant, otherwise hold
  always_comb begin
    ptr_d    = ptr_q;
    rvalid_d = 1'b0;
    rid_d    = rid_q;
    y_d      = y_q;
    cb_d     = cb_q;
    if (grant_valid_s) begin
      rvalid_d = 1'b1;
      rid_d    = grant_idx_s;
      y_d      = sum_s[WIDTH-1:0];
      cb_d     = sum_s[WIDTH];
      // Pointer moves just past the granted requester (owner+1 when a chain ends)
      if (grant_idx_s == IDW'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx_s + IDW'(1);
      end
    end else begin
      rvalid_d = 1'b0;
    end
  end

`ifdef ADDER_ARB_CHAIN_EN
  // Chain FSM: enter LOCKED on a LOCK grant, leave after the owner's last word
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    carry_d = carry_q;
    case (state_q)
      ST_ARB: begin
        if (grant_valid_s && LOCK[grant_idx_s]) begin
          state_d = ST_LOCKED;
          owner_d = grant_idx_s;
          carry_d = sum_s[WIDTH];
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_LOCKED: begin
        if (grant_valid_s) begin
          carry_d = sum_s[WIDTH];
          if (!LOCK[owner_q]) begin
            state_d = ST_ARB;
          end else begin
            state_d = ST_LOCKED;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_ARB;
        owner_d = '0;
        carry_d = 1'b0;
      end
    endcase
  end

  // Chain state registers; reset abandons any chain in progress
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_ARB;
      owner_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      carry_q <= carry_d;
    end
  end
`endif

  // Pointer and result registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ptr_q    <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      y_q      <= '0;
      cb_q     <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      y_q      <= y_d;
      cb_q     <= cb_d;
    end
  end

  assign GNT    = gnt_s;
  assign RVALID = rvalid_q;
  assign RID    = rid_q;
  assign Y      = y_q;
  assign CB     = cb_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed testbench for adder_arbiter (NREQ=4, WIDTH=32). Inputs are driven
// 1 ns after the rising edge; GNT is checked in the same cycle, registered
// outputs 1 ns after the following rising edge.
module tb_adder_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  CLK;
  logic                  RSTN;
  logic [NREQ-1:0]       REQ;
  logic [NREQ*WIDTH-1:0] A_IN;
  logic [NREQ*WIDTH-1:0] B_IN;
`ifdef ADDER_ARB_CHAIN_EN
  logic [NREQ-1:0]       LOCK;
`endif
  logic [NREQ-1:0]       GNT;
  logic                  RVALID;
  logic [1:0]            RID;
  logic [WIDTH-1:0]      Y;
  logic                  CB;

  int checks;
  int failures;

  adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .REQ   (REQ),
    .A_IN  (A_IN),
    .B_IN  (B_IN),
`ifdef ADDER_ARB_CHAIN_EN
    .LOCK  (LOCK),
`endif
    .GNT   (GNT),
    .RVALID(RVALID),
    .RID   (RID),
    .Y     (Y),
    .CB    (CB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    A_IN[i*WIDTH +: WIDTH] = a;
    B_IN[i*WIDTH +: WIDTH] = b;
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Synchronous-looking reset pulse placed between edges
  task automatic do_reset();
    RSTN = 1'b0;
    #2;
    RSTN = 1'b1;
    #1;
  endtask

  task automatic check_result(input string tag, input logic [1:0] rid,
                              input logic [31:0] y, input logic cb);
    check_eq({tag, "_rvalid"}, 64'(RVALID), 64'd1);
    check_eq({tag, "_rid"},    64'(RID),    64'(rid));
    check_eq({tag, "_y"},      64'(Y),      64'(y));
    check_eq({tag, "_cb"},     64'(CB),     64'(cb));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RSTN     = 1'b0;
    REQ      = 4'b1111;
    A_IN     = '0;
    B_IN     = '0;
`ifdef ADDER_ARB_CHAIN_EN
    LOCK     = 4'b0000;
`endif

    // Reset state: grant forced off, outputs cleared
    #12;
    check_eq("rst_gnt",    64'(GNT),    64'd0);
    check_eq("rst_rvalid", 64'(RVALID), 64'd0);
    check_eq("rst_y",      64'(Y),      64'd0);
    check_eq("rst_cb",     64'(CB),     64'd0);
    check_eq("rst_rid",    64'(RID),    64'd0);
    REQ = 4'b0000;
    step();
    RSTN = 1'b1;
    step();

    // Single request, wrap to zero with carry out
    REQ = 4'b0100;
    set_op(2, 32'hFFFF_FFFF, 32'h0000_0001);
    #1;
    check_eq("single_gnt", 64'(GNT), 64'd4);
    step();
    check_result("single", 2'd2, 32'h0000_0000, 1'b1);

    // Idle: no grant, result held
    REQ = 4'b0000;
    #1;
    check_eq("idle_gnt", 64'(GNT), 64'd0);
    step();
    check_eq("idle_rvalid", 64'(RVALID), 64'd0);
    check_eq("idle_y_hold", 64'(Y),      64'd0);
    check_eq("idle_cb_hold",64'(CB),     64'd1);
    check_eq("idle_rid_hold",64'(RID),   64'd2);

    // All requesting after reset: order 0,1,2,3,0,1,2,3 every cycle
    do_reset();
    set_op(0, 32'h0000_0010, 32'h0000_0001);
    set_op(1, 32'h0000_0020, 32'h0000_0002);
    set_op(2, 32'h8000_0000, 32'h8000_0003);
    set_op(3, 32'h1234_0000, 32'h0000_5678);
    REQ = 4'b1111;
    begin
      logic [31:0] exp_y [4];
      logic        exp_c [4];
      exp_y[0] = 32'h0000_0011; exp_c[0] = 1'b0;
      exp_y[1] = 32'h0000_0022; exp_c[1] = 1'b0;
      exp_y[2] = 32'h0000_0003; exp_c[2] = 1'b1;
      exp_y[3] = 32'h1234_5678; exp_c[3] = 1'b0;
      for (int c = 0; c < 8; c++) begin
        #1;
        check_eq("rr_gnt", 64'(GNT), 64'(4'b0001 << (c % 4)));
        step();
        check_result("rr", 2'(c % 4), exp_y[c % 4], exp_c[c % 4]);
      end
    end

    // Move pointer to 2 by granting requester 1, then REQ=1010 gives 3 then 1
    REQ = 4'b0010;
    step();
    REQ = 4'b1010;
    #1;
    check_eq("ptr2_gnt_a", 64'(GNT), 64'd8);
    step();
    check_result("ptr2_a", 2'd3, 32'h1234_5678, 1'b0);
    #1;
    check_eq("ptr2_gnt_b", 64'(GNT), 64'd2);
    step();
    check_result("ptr2_b", 2'd1, 32'h0000_0022, 1'b0);
    REQ = 4'b0000;
    step();

    // Two-word add from requester 0 while requester 1 also requests
    do_reset();
    REQ = 4'b0011;
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
    set_op(1, 32'h0000_0005, 32'h0000_0007);
`ifdef ADDER_ARB_CHAIN_EN
    LOCK = 4'b0001;
`endif
    #1;
    check_eq("chain_w0_gnt", 64'(GNT), 64'd1);
    step();
    check_result("chain_w0", 2'd0, 32'h0000_0000, 1'b1);
    set_op(0, 32'h0000_0000, 32'h0000_0000);
`ifdef ADDER_ARB_CHAIN_EN
    LOCK = 4'b0000;
    #1;
    check_eq("chain_w1_gnt", 64'(GNT), 64'd1);
    step();
    check_result("chain_w1", 2'd0, 32'h0000_0001, 1'b0);
    REQ = 4'b0010;
    #1;
    check_eq("chain_r1_gnt", 64'(GNT), 64'd2);
    step();
    check_result("chain_r1", 2'd1, 32'h0000_000C, 1'b0);
`else
    #1;
    check_eq("nochain_r1_gnt", 64'(GNT), 64'd2);
    step();
    check_result("nochain_r1", 2'd1, 32'h0000_000C, 1'b0);
    #1;
    check_eq("nochain_w1_gnt", 64'(GNT), 64'd1);
    step();
    check_result("nochain_w1", 2'd0, 32'h0000_0000, 1'b0);
`endif
    REQ = 4'b0000;
    step();

`ifdef ADDER_ARB_CHAIN_EN
    // Reset between chained words abandons the saved carry
    do_reset();
    REQ  = 4'b0001;
    LOCK = 4'b0001;
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
    step();
    check_result("abort_w0", 2'd0, 32'h0000_0000, 1'b1);
    RSTN = 1'b0;
    #1;
    check_eq("abort_rst_gnt",    64'(GNT),    64'd0);
    check_eq("abort_rst_rvalid", 64'(RVALID), 64'd0);
    check_eq("abort_rst_y",      64'(Y),      64'd0);
    check_eq("abort_rst_cb",     64'(CB),     64'd0);
    check_eq("abort_rst_rid",    64'(RID),    64'd0);
    RSTN = 1'b1;
    LOCK = 4'b0000;
    set_op(0, 32'h0000_0000, 32'h0000_0000);
    #1;
    check_eq("abort_w1_gnt", 64'(GNT), 64'd1);
    step();
    check_result("abort_w1", 2'd0, 32'h0000_0000, 1'b0);
    REQ = 4'b0000;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
